// File: rtl/frame_buffer_pkg.sv
// Shared encodings for the frame buffer: command opcodes and controller states.
package frame_buffer_pkg;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CLEAR
    } state_e;
endpackage

// File: rtl/frame_buffer_rwm_if.sv
// Command, pixel-in, pixel-out and status signals of the frame buffer.
interface frame_buffer_rwm_if #(parameter int DATA_W = 8);
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic              cmd_ready;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, abort, in_data, in_valid, out_ready,
        input  cmd_ready, in_ready, out_data, out_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, abort, in_data, in_valid, out_ready,
        output cmd_ready, in_ready, out_data, out_valid, busy, done, err
    );
endinterface

// File: rtl/frame_buffer_ram.sv
// Single-port synchronous RAM: write on the edge, registered read, no reset.
module frame_buffer_ram #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 4,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/frame_buffer_rwm.sv
// Frame store controller: read/write/clear FSM, pointers and the one-entry
// registered output stage in front of the single-port RAM.
module frame_buffer_rwm
    import frame_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_H  = 2,
    parameter int IMG_W  = 2
) (
    input logic               clk,
    input logic               rst_n,
    frame_buffer_rwm_if.slave bus
);
    localparam int DEPTH  = IMG_H * IMG_W;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    state_e            state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  cnt, cnt_nxt;
    logic              pend, pend_nxt;
    logic              ov, ov_nxt;
    logic [DATA_W-1:0] od, od_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;

    logic              we;
    logic [DATA_W-1:0] wdata, rdata;
    logic [PTR_W-1:0]  ram_ptr;
    logic [ADDR_W-1:0] ram_addr;
    logic              in_rdy, wr_beat, xfer, load;

    assign in_rdy  = (state == WRITE) & ~bus.abort;
    assign wr_beat = bus.in_valid & in_rdy;
    assign xfer    = ov & bus.out_ready;
    // pend: RAM output holds mem[ptr]; set one cycle into READ so the first
    // word appears two edges after the command.
    assign load    = pend & (~ov | bus.out_ready);

    // In READ the RAM is addressed with the next pointer so a word is ready
    // every cycle while the output stage keeps draining.
    assign ram_ptr  = (state == READ) ? ptr_nxt : ptr;
    assign ram_addr = (ram_ptr < DEPTH_P) ? ram_ptr[ADDR_W-1:0] : '0;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        pend_nxt  = 1'b0;
        ov_nxt    = ov;
        od_nxt    = od;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        we        = 1'b0;
        wdata     = bus.in_data;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ptr_nxt = '0;
                    cnt_nxt = '0;
                    case (bus.cmd_op)
                        OP_READ:  state_nxt = READ;
                        OP_WRITE: state_nxt = WRITE;
                        OP_CLEAR: state_nxt = CLEAR;
                        default:  err_nxt   = 1'b1;
                    endcase
                end
            end
            WRITE: begin
                if (wr_beat) begin
                    we      = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    if (ptr == LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                we      = ~bus.abort;
                wdata   = '0;
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            READ: begin
                if (load) begin
                    od_nxt  = rdata;
                    ov_nxt  = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                end else if (xfer) begin
                    od_nxt = '0;
                    ov_nxt = 1'b0;
                end
                if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                pend_nxt = (ptr_nxt < DEPTH_P);
            end
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && bus.abort) begin
            state_nxt = IDLE;
            ov_nxt    = 1'b0;
            od_nxt    = '0;
            pend_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            ov     <= 1'b0;
            od     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            pend   <= pend_nxt;
            ov     <= ov_nxt;
            od     <= od_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    frame_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign bus.cmd_ready = (state == IDLE);
    assign bus.in_ready  = in_rdy;
    assign bus.out_data  = od;
    assign bus.out_valid = ov;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/frame_buffer_rwm.md
Name: frame_buffer_rwm

Overview:
- Parametrised image frame store for the camera and grayscale pipeline.
- Holds IMG_H*IMG_W pixels of DATA_W bits each.
- Controller issues read, write or clear commands over a valid/ready command port.
- Pixels enter and leave on valid/ready streams with full backpressure. Output never tri-states.
- Supports abort and reports illegal opcodes.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_H, 2, image height in pixels
- IMG_W, 2, image width in pixels
- Derived (not overridable): DEPTH = IMG_H*IMG_W; ADDR_W = max(1, clog2(DEPTH))

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_op  in  2  00 read, 01 write, 10 clear, 11 reserved
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- abort  in  1  synchronous cancel of the current operation
- in_data  in  DATA_W  write pixel
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a write pixel
- out_data  out  DATA_W  read pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts a pixel
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  one-cycle pulse when a reserved opcode is accepted

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE, addresses 0
  - out_valid 0, out_data 0, done 0, err 0, busy 0
  - memory contents are not reset
- States: IDLE, WRITE, READ, CLEAR.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) at an edge enters READ, WRITE or CLEAR with addr=0.
  - Op 11 is accepted, pulses err the next cycle and stays in IDLE.
- WRITE:
  - in_ready = (state==WRITE) & ~abort.
  - Each in_valid & in_ready beat writes mem[addr] and increments addr.
  - in_valid low simply stalls; addr is held.
  - The beat at addr==DEPTH-1 returns the block to IDLE and pulses done in the first IDLE cycle.
- READ:
  - One-entry registered output stage.
  - While the read address is below DEPTH and (~out_valid | out_ready), mem[rd_addr] loads into out_data, out_valid is set and rd_addr increments.
  - First out_valid appears 2 cycles after the command handshake edge. Throughput is 1 pixel/cycle with out_ready held high.
  - out_data is stable while out_valid & ~out_ready.
  - A transfer with count==DEPTH-1 clears out_valid, returns to IDLE and pulses done.
  - out_data is 0 whenever out_valid=0.
- CLEAR:
  - Writes 0 to mem[addr], one word per cycle, for exactly DEPTH cycles.
  - Then IDLE plus a done pulse.
- abort:
  - In any non-IDLE state, the next edge goes to IDLE.
  - out_valid cleared, no done pulse, already-written words kept.
  - In IDLE, abort has no effect.
- abort coincident with a read transfer (out_valid & out_ready): the transfer counts downstream, but no done is produced.
- cmd_valid outside IDLE is ignored (cmd_ready=0). A command may be accepted in the same cycle done is high.
- Reads and writes are never concurrent, so the memory is single-port synchronous: write on the clock edge, 1-cycle read.
- DEPTH=1 is legal: each operation is a single beat.

Decomposition:
- Package frame_buffer_pkg holds:
  - cmd_op encodings OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD
  - state enum IDLE/WRITE/READ/CLEAR
- Sub-module frame_buffer_ram is a single-port synchronous RAM, parameters DATA_W and DEPTH, ports clk/we/addr/wdata/rdata. Memory is not reset.
- The FSM, counters and output register live in the top module.

Test Plan (IMG_H=2, IMG_W=2, DEPTH=4, DATA_W=8):
- Write 11,22,33,44 with in_valid gapped every other cycle, then read with out_ready=1:
  - in_ready stays high through the gaps; done pulses once after the 4th beat.
  - Read returns 11,22,33,44 on consecutive cycles, then done; busy drops.
- Read with out_ready toggling 1,0,0,1,…:
  - out_data is held stable while stalled; exactly 4 transfers occur, in order.
  - done is produced only after the 4th transfer.
- Clear, then read:
  - CLEAR lasts exactly 4 cycles, then done.
  - Read returns 00,00,00,00.
- Write AA,BB, assert abort, then read:
  - Abort gives no done and a return to IDLE.
  - Read returns AA,BB followed by the prior contents at addresses 2 and 3.
- cmd_op=11:
  - err pulses 1 cycle, busy stays 0.
  - A cmd_valid during an active WRITE is not accepted (cmd_ready=0).
- Assert rst_n low mid-READ:
  - out_valid, out_data and busy are 0 immediately.
  - A following read returns the previous memory contents.
